dbus_ram: RTL and testbench



---
 rtl/dbus_ram_pkg.sv | 21 ++
 rtl/dbus_ram_array.sv | 35 +++
 rtl/dbus_ram.sv | 116 +++++++++++
 tb/tb_dbus_ram.sv | 217 +++++++++++++++++++++
 4 files changed

// File: rtl/dbus_ram_pkg.sv
// Shared types for the data-bus RAM responder.
// Holds the FSM state encoding, request bundle and out-of-range read pattern.
package pck_dbus;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_WAIT,
        ST_RESP
    } dbus_ram_state_e;

    localparam logic [31:0] DBUS_OOR_DATA = 32'hDEADBEEF;

    typedef struct packed {
        logic [31:0] addr;
        logic [3:0]  be;
        logic [31:0] wr_data;
        logic        wr;
        logic        rd;
    } dbus_req_t;

endpackage

// File: rtl/dbus_ram_array.sv
// Single-port word RAM with per-byte write enables and a registered read port.
// The read register only loads on a read, so it holds the last read word.
module dbus_ram_array #(
    parameter int unsigned p_addr_width = 10
) (
    input  logic                    i_clk,
    input  logic                    i_rst_n,
    input  logic                    we,
    input  logic [3:0]              be,
    input  logic                    re,
    input  logic [p_addr_width-1:0] addr,
    input  logic [31:0]             wdata,
    output logic [31:0]             rdata
);

    logic [31:0] mem [2**p_addr_width];

    always_ff @(posedge i_clk) begin
        if (we) begin
            for (int n = 0; n < 4; n++) begin
                if (be[n]) mem[addr][8*n +: 8] <= wdata[8*n +: 8];
            end
        end
    end

    // Contents are never reset; only the output register is.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            rdata <= '0;
        end else if (re) begin
            rdata <= mem[addr];
        end
    end

endmodule

// File: rtl/dbus_ram.sv
// Data-bus responder in front of a tightly coupled data RAM, optional wait states.
// Define DBUS_RAM_BOUNDS_EN to drop/flag accesses outside the mapped window.
module dbus_ram
    import pck_dbus::*;
#(
    parameter int unsigned p_addr_width  = 10,
    parameter int unsigned p_wait_states = 0,
    parameter logic [31:0] p_base_addr   = 32'h0000_0000
) (
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic [31:0] dbus_addr,
    input  logic [3:0]  dbus_be,
    input  logic        dbus_wr_en,
    input  logic [31:0] dbus_wr_data,
    input  logic        dbus_rd_en,
    output logic [31:0] dbus_rd_data,
    output logic        dbus_busy,
    output logic        dbus_ack
);

    localparam bit          ZERO_WS = (p_wait_states == 0);
    localparam logic [3:0]  WAIT_LD =
        ZERO_WS ? 4'd0 : 4'(p_wait_states - 1);

    dbus_ram_state_e state, state_d;
    logic [3:0]      cnt, cnt_d;
    dbus_req_t       req_q, req_in, op;
    logic            accept, fire, in_range, oor_q;
    logic            mem_we, mem_re;
    logic [31:0]     off, arr_rdata;

    assign req_in = '{
        addr:    dbus_addr,
        be:      dbus_be,
        wr_data: dbus_wr_data,
        wr:      dbus_wr_en,
        rd:      dbus_rd_en
    };

    assign accept = (state == ST_IDLE || state == ST_RESP)
                  && (dbus_wr_en || dbus_rd_en);

    // Zero wait states act on the live request; otherwise on the latched one.
    assign op   = ZERO_WS ? req_in : req_q;
    assign fire = i_rst_n && (ZERO_WS ? accept
                                      : (state == ST_WAIT && cnt == 4'd0));

    assign off = op.addr - p_base_addr;

`ifdef DBUS_RAM_BOUNDS_EN
    assign in_range = (off >> (p_addr_width + 2)) == 32'd0;
`else
    logic unused_hi;
    assign unused_hi = ^off[31:p_addr_width+2];
    assign in_range  = 1'b1;
`endif

    logic unused_lo;
    assign unused_lo = ^off[1:0];

    assign mem_we = fire && op.wr && in_range;
    assign mem_re = fire && op.rd && !op.wr;

    always_comb begin
        state_d = state;
        cnt_d   = cnt;
        unique case (state)
            ST_IDLE, ST_RESP: begin
                if (accept) begin
                    state_d = ZERO_WS ? ST_RESP : ST_WAIT;
                    cnt_d   = WAIT_LD;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_WAIT: begin
                if (cnt == 4'd0) state_d = ST_RESP;
                else             cnt_d   = cnt - 4'd1;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state <= ST_IDLE;
            cnt   <= 4'd0;
            req_q <= '0;
            oor_q <= 1'b0;
        end else begin
            state <= state_d;
            cnt   <= cnt_d;
            if (accept) req_q <= req_in;
            if (mem_re) oor_q <= !in_range;
        end
    end

    dbus_ram_array #(
        .p_addr_width (p_addr_width)
    ) u_array (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .we      (mem_we),
        .be      (op.be),
        .re      (mem_re),
        .addr    (off[p_addr_width+1:2]),
        .wdata   (op.wr_data),
        .rdata   (arr_rdata)
    );

    assign dbus_rd_data = oor_q ? DBUS_OOR_DATA : arr_rdata;
    assign dbus_busy    = (state == ST_WAIT);
    assign dbus_ack     = (state == ST_RESP);

endmodule

// File: tb/tb_dbus_ram.sv
// Bench for dbus_ram: three instances (0, 3 and 2 wait states, 16 words each)
// driven by directed and random transactions against a word-array model.
module tb_dbus_ram;

    localparam int NW = 16;

    logic        clk = 1'b0;
    logic        rst_n [3];
    logic [31:0] addr  [3];
    logic [31:0] wdata [3];
    logic [31:0] rdata [3];
    logic [3:0]  be    [3];
    logic        wr    [3];
    logic        rd    [3];
    logic        busy  [3];
    logic        ack   [3];

    int          ws [3] = '{0, 3, 2};
    logic [31:0] mem    [3][NW];
    logic [31:0] exp_rd [3];
    int          total = 0;
    int          bad   = 0;

    always #5 clk = ~clk;

    dbus_ram #(.p_addr_width(4), .p_wait_states(0)) u0 (
        .i_clk(clk), .i_rst_n(rst_n[0]), .dbus_addr(addr[0]),
        .dbus_be(be[0]), .dbus_wr_en(wr[0]), .dbus_wr_data(wdata[0]),
        .dbus_rd_en(rd[0]), .dbus_rd_data(rdata[0]),
        .dbus_busy(busy[0]), .dbus_ack(ack[0])
    );

    dbus_ram #(.p_addr_width(4), .p_wait_states(3)) u1 (
        .i_clk(clk), .i_rst_n(rst_n[1]), .dbus_addr(addr[1]),
        .dbus_be(be[1]), .dbus_wr_en(wr[1]), .dbus_wr_data(wdata[1]),
        .dbus_rd_en(rd[1]), .dbus_rd_data(rdata[1]),
        .dbus_busy(busy[1]), .dbus_ack(ack[1])
    );

    dbus_ram #(.p_addr_width(4), .p_wait_states(2)) u2 (
        .i_clk(clk), .i_rst_n(rst_n[2]), .dbus_addr(addr[2]),
        .dbus_be(be[2]), .dbus_wr_en(wr[2]), .dbus_wr_data(wdata[2]),
        .dbus_rd_en(rd[2]), .dbus_rd_data(rdata[2]),
        .dbus_busy(busy[2]), .dbus_ack(ack[2])
    );

    task automatic chk(string tag, logic [31:0] o, logic [31:0] e);
        total++;
        assert (o === e) else begin
            bad++;
            $error("FAIL %s obs=%h exp=%h", tag, o, e);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(int k);
        wr[k] = 1'b0;
        rd[k] = 1'b0;
    endtask

    function automatic bit inr(logic [31:0] a);
`ifdef DBUS_RAM_BOUNDS_EN
        return a < 32'(4 * NW);
`else
        return 1'b1;
`endif
    endfunction

    function automatic int wi(logic [31:0] a);
        return int'((a / 4) % NW);
    endfunction

    // One request: presented for one cycle, then busy/ack timing and data checked.
    task automatic xact(int k, bit w, bit r, logic [31:0] a,
                        logic [3:0] b, logic [31:0] d, bit intr);
        addr[k]  = a;
        be[k]    = b;
        wdata[k] = d;
        wr[k]    = w;
        rd[k]    = r;
        tick();
        idle(k);
        for (int i = 0; i < ws[k]; i++) begin
            chk("busy_wait", busy[k], 1);
            chk("ack_early", ack[k], 0);
            if (intr && i == 1) begin
                addr[k]  = a;
                be[k]    = 4'hF;
                wdata[k] = ~d;
                wr[k]    = 1'b1;
            end
            if (intr && i == 2) idle(k);
            tick();
        end
        chk("ack", ack[k], 1);
        chk("busy_resp", busy[k], 0);
        if (w) begin
            if (inr(a)) begin
                for (int n = 0; n < 4; n++) begin
                    if (b[n]) mem[k][wi(a)][8*n +: 8] = d[8*n +: 8];
                end
            end
        end else begin
            exp_rd[k] = inr(a) ? mem[k][wi(a)] : 32'hDEADBEEF;
        end
        chk("rd_data", rdata[k], exp_rd[k]);
    endtask

    initial begin
        for (int k = 0; k < 3; k++) begin
            rst_n[k]  = 1'b0;
            addr[k]   = '0;
            wdata[k]  = '0;
            be[k]     = '0;
            idle(k);
            exp_rd[k] = '0;
        end
        #12;
        for (int k = 0; k < 3; k++) begin
            chk("rst_rd_data", rdata[k], 0);
            chk("rst_busy", busy[k], 0);
            chk("rst_ack", ack[k], 0);
        end
        @(negedge clk);
        for (int k = 0; k < 3; k++) rst_n[k] = 1'b1;
        tick();

        // Known contents everywhere before any read.
        for (int k = 0; k < 3; k++) begin
            for (int i = 0; i < NW; i++) begin
                xact(k, 1, 0, 32'(i * 4), 4'hF, $urandom, 0);
            end
            tick();
            chk("ack_idle", ack[k], 0);
        end

        // Zero wait states: full word, lane write, read-after-write.
        xact(0, 1, 0, 32'h10, 4'hF, 32'h1234_5678, 0);
        xact(0, 0, 1, 32'h10, 4'h0, 32'h0, 0);
        chk("w0_full", rdata[0], 32'h1234_5678);
        xact(0, 1, 0, 32'h10, 4'b0100, 32'h00AB_0000, 0);
        xact(0, 0, 1, 32'h10, 4'h0, 32'h0, 0);
        chk("w0_lane2", rdata[0], 32'h12AB_5678);

        // Write wins over a simultaneous read.
        xact(0, 1, 1, 32'h4, 4'hF, 32'hCAFE_F00D, 0);
        chk("wr_rd_hold", rdata[0], 32'h12AB_5678);
        xact(0, 0, 1, 32'h4, 4'h0, 32'h0, 0);
        chk("wr_rd_data", rdata[0], 32'hCAFE_F00D);

        // Address just past the array: wrap or out-of-range.
        xact(0, 0, 1, 32'h40, 4'h0, 32'h0, 0);
`ifdef DBUS_RAM_BOUNDS_EN
        chk("oor_read", rdata[0], 32'hDEADBEEF);
`else
        chk("wrap_read", rdata[0], mem[0][0]);
`endif
        xact(0, 1, 0, 32'h40, 4'hF, 32'h5555_AAAA, 0);
        xact(0, 0, 1, 32'h0, 4'h0, 32'h0, 0);
        xact(0, 1, 0, 32'h0, 4'hF, 32'h0BAD_F00D, 0);
        xact(0, 0, 1, 32'h0, 4'h0, 32'h0, 0);

        // Three wait states, with a write presented while busy.
        xact(1, 0, 1, 32'h8, 4'h0, 32'h7777_0000, 1);
        xact(1, 0, 1, 32'h8, 4'h0, 32'h0, 0);
        tick();
        chk("w3_idle_ack", ack[1], 0);

        // Reset pulsed while a write is waiting.
        xact(2, 1, 0, 32'h20, 4'hF, 32'h1111_2222, 0);
        tick();
        addr[2]  = 32'h20;
        be[2]    = 4'hF;
        wdata[2] = 32'hBAD0_BAD0;
        wr[2]    = 1'b1;
        tick();
        idle(2);
        chk("abort_busy_pre", busy[2], 1);
        #1 rst_n[2] = 1'b0;
        #1;
        chk("abort_busy", busy[2], 0);
        chk("abort_ack", ack[2], 0);
        chk("abort_rd_data", rdata[2], 0);
        exp_rd[2] = '0;
        @(negedge clk);
        rst_n[2] = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("abort_no_ack", ack[2], 0);
        end
        xact(2, 0, 1, 32'h20, 4'h0, 32'h0, 0);
        chk("abort_old", rdata[2], 32'h1111_2222);

        // Random traffic, mostly back-to-back with occasional idle cycles.
        for (int k = 0; k < 3; k++) begin
            for (int i = 0; i < 150; i++) begin
                logic [1:0] opk;
                opk = 2'($urandom_range(1, 3));
                xact(k, opk[0], opk[1], 32'($urandom_range(0, 31) * 4),
                     4'($urandom), $urandom, 0);
                if ($urandom_range(0, 3) == 0) begin
                    tick();
                    chk("rnd_idle_ack", ack[k], 0);
                    chk("rnd_idle_busy", busy[k], 0);
                end
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
